// File: rtl/sequential_pkg.sv
// Shared encodings for the sequential-circuit library: count direction and
// boundary behaviour selectors.
package sequential_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

endpackage

// File: rtl/mod_step_next.sv
// Combinational next-count unit: given the current count, step, limit,
// direction and boundary mode, produce the next count and event flags.
module mod_step_next
    import sequential_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] q,
    input  logic [N-1:0] step,
    input  logic [N-1:0] limit,
    input  logic         up,
    input  logic         sat_mode,
    output logic [N-1:0] q_next,
    output logic         wrap_flag,
    output logic         sat_flag
);

    localparam logic [N:0] ONE = {{N{1'b0}}, 1'b1};

    // All arithmetic is carried in N+1 bits so limit+1 = 2^N and q+step
    // never lose a carry.
    logic [N:0] q_x;
    logic [N:0] lim_x;
    logic [N:0] step_eff;
    logic [N:0] modulus;
    logic [N:0] sum;

    always_comb begin
        q_x      = {1'b0, q};
        lim_x    = {1'b0, limit};
        // Clamping the step to the limit means one correction always
        // brings an overflowing or underflowing count back into 0..limit.
        step_eff = (step > limit) ? lim_x : {1'b0, step};
        modulus  = lim_x + ONE;
        sum      = q_x + step_eff;
    end

    always_comb begin
        q_next    = q;
        wrap_flag = 1'b0;
        sat_flag  = 1'b0;

        if (q_x > lim_x) begin
            // Limit was lowered below the current count: pull back in range.
            q_next = limit;
        end else if (up == DIR_UP) begin
            if (sum > lim_x) begin
                if (sat_mode == MODE_SAT) begin
                    q_next   = limit;
                    sat_flag = 1'b1;
                end else begin
                    q_next    = N'(sum - modulus);
                    wrap_flag = 1'b1;
                end
            end else begin
                q_next = N'(sum);
            end
        end else begin
            if (step_eff > q_x) begin
                if (sat_mode == MODE_SAT) begin
                    q_next   = '0;
                    sat_flag = 1'b1;
                end else begin
                    q_next    = N'(q_x + modulus - step_eff);
                    wrap_flag = 1'b1;
                end
            end else begin
                q_next = N'(q_x - step_eff);
            end
        end
    end

endmodule

// File: rtl/mod_step_up_down_counter.sv
// Up/down counter with programmable modulus and step, parallel load, and
// per-cycle wrap/saturate selection; wrap and saturation reported as pulses.
module mod_step_up_down_counter
    import sequential_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         up,
    input  logic         sat_mode,
    input  logic [N-1:0] step,
    input  logic [N-1:0] limit,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] Q,
    output logic         at_max,
    output logic         at_min,
    output logic         wrap_evt,
    output logic         sat_evt
);

    logic [N-1:0] q_next;
    logic         wrap_flag;
    logic         sat_flag;
    logic [N-1:0] load_clamped;

    mod_step_next #(
        .N(N)
    ) u_next (
        .q        (Q),
        .step     (step),
        .limit    (limit),
        .up       (up),
        .sat_mode (sat_mode),
        .q_next   (q_next),
        .wrap_flag(wrap_flag),
        .sat_flag (sat_flag)
    );

    assign load_clamped = (load_val > limit) ? limit : load_val;

    // Event pulses are cleared on every edge that is not an enabled count,
    // so they only ever last one cycle and line up with the new Q.
    always_ff @(posedge clk) begin
        if (reset) begin
            Q        <= '0;
            wrap_evt <= 1'b0;
            sat_evt  <= 1'b0;
        end else if (load) begin
            Q        <= load_clamped;
            wrap_evt <= 1'b0;
            sat_evt  <= 1'b0;
        end else if (enable) begin
            Q        <= q_next;
            wrap_evt <= wrap_flag;
            sat_evt  <= sat_flag;
        end else begin
            wrap_evt <= 1'b0;
            sat_evt  <= 1'b0;
        end
    end

    assign at_max = (Q == limit);
    assign at_min = (Q == '0);

endmodule

// File: tb/tb_mod_step_up_down_counter.sv
// Bench for mod_step_up_down_counter: directed vector table, a mid-cycle
// reset sequence, and randomized traffic against an arithmetic reference model.
module tb_mod_step_up_down_counter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         up;
    logic         sat_mode;
    logic [N-1:0] step;
    logic [N-1:0] limit;
    logic         load;
    logic [N-1:0] load_val;
    logic [N-1:0] Q;
    logic         at_max;
    logic         at_min;
    logic         wrap_evt;
    logic         sat_evt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mod_step_up_down_counter #(
        .N(N)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .up      (up),
        .sat_mode(sat_mode),
        .step    (step),
        .limit   (limit),
        .load    (load),
        .load_val(load_val),
        .Q       (Q),
        .at_max  (at_max),
        .at_min  (at_min),
        .wrap_evt(wrap_evt),
        .sat_evt (sat_evt)
    );

    typedef struct {
        logic     rst;
        logic     ld;
        logic     en;
        logic     up;
        logic     sat;
        int       step;
        int       lim;
        int       ldv;
        int       q;
        logic     w;
        logic     s;
        logic     mx;
        logic     mn;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic ld, input logic en,
                                input logic u, input logic sat, input int stp,
                                input int lim, input int ldv, input int q,
                                input logic w, input logic s, input logic mx,
                                input logic mn);
        vec_t v;
        v.rst = rst; v.ld = ld; v.en = en; v.up = u; v.sat = sat;
        v.step = stp; v.lim = lim; v.ldv = ldv;
        v.q = q; v.w = w; v.s = s; v.mx = mx; v.mn = mn;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic ld, input logic en,
                         input logic u, input logic sat, input int stp,
                         input int lim, input int ldv);
        @(negedge clk);
        reset    = rst;
        load     = ld;
        enable   = en;
        up       = u;
        sat_mode = sat;
        step     = N'(stp);
        limit    = N'(lim);
        load_val = N'(ldv);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int q, input logic w,
                             input logic s, input logic mx, input logic mn);
        check({tag, "_q"},    int'(Q),        q);
        check({tag, "_wrap"}, int'(wrap_evt), int'(w));
        check({tag, "_sat"},  int'(sat_evt),  int'(s));
        check({tag, "_max"},  int'(at_max),   int'(mx));
        check({tag, "_min"},  int'(at_min),   int'(mn));
    endtask

    // Reference model state, derived from the counting rules with plain
    // modular arithmetic.
    int mq;
    int mw;
    int ms;

    function automatic void model(input logic rst, input logic ld, input logic en,
                                  input logic u, input logic sat, input int stp,
                                  input int lim, input int ldv);
        int m;
        int se;
        m  = lim + 1;
        se = (stp < lim) ? stp : lim;
        mw = 0;
        ms = 0;
        if (rst) begin
            mq = 0;
        end else if (ld) begin
            mq = (ldv < lim) ? ldv : lim;
        end else if (en) begin
            if (mq > lim) begin
                mq = lim;
            end else if (u) begin
                if (mq + se >= m) begin
                    if (sat) begin mq = lim; ms = 1; end
                    else     begin mq = (mq + se) % m; mw = 1; end
                end else begin
                    mq = mq + se;
                end
            end else begin
                if (se > mq) begin
                    if (sat) begin mq = 0; ms = 1; end
                    else     begin mq = (mq - se + m) % m; mw = 1; end
                end else begin
                    mq = mq - se;
                end
            end
        end
    endfunction

    initial begin
        int cur_lim;
        reset = 1'b1; load = 1'b0; enable = 1'b0; up = 1'b1; sat_mode = 1'b0;
        step = '0; limit = '0; load_val = '0;

        //   rst ld en up sat step lim ldv   q  w  s  mx mn
        // Reset dominates load and enable.
        add(1, 1, 1, 1, 0, 1, 9, 5,      0, 0, 0, 0, 1);
        add(1, 1, 1, 1, 0, 1, 9, 5,      0, 0, 0, 0, 1);
        // Count 1..9 then wrap to 0.
        for (int i = 1; i <= 9; i++)
            add(0, 0, 1, 1, 0, 1, 9, 0,  i, 0, 0, (i == 9), 0);
        add(0, 0, 1, 1, 0, 1, 9, 0,      0, 1, 0, 0, 1);
        // Saturating up by 3.
        add(0, 0, 1, 1, 1, 3, 9, 0,      3, 0, 0, 0, 0);
        add(0, 0, 1, 1, 1, 3, 9, 0,      6, 0, 0, 0, 0);
        add(0, 0, 1, 1, 1, 3, 9, 0,      9, 0, 0, 1, 0);
        add(0, 0, 1, 1, 1, 3, 9, 0,      9, 0, 1, 1, 0);
        add(0, 0, 0, 1, 1, 3, 9, 0,      9, 0, 0, 1, 0);
        // Down wrap, down saturate, exact landing on zero.
        add(0, 1, 1, 0, 0, 3, 9, 1,      1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 3, 9, 0,      8, 1, 0, 0, 0);
        add(0, 1, 1, 0, 1, 3, 9, 1,      1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 3, 9, 0,      0, 0, 1, 0, 1);
        add(0, 1, 1, 0, 0, 3, 9, 3,      3, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 3, 9, 0,      0, 0, 0, 0, 1);
        // Load is clamped to limit and beats counting.
        add(0, 1, 1, 1, 0, 1, 9, 12,     9, 0, 0, 1, 0);
        add(0, 1, 1, 1, 0, 1, 9, 4,      4, 0, 0, 0, 0);
        // Runtime limit changes.
        add(0, 1, 1, 0, 0, 1, 9, 9,      9, 0, 0, 1, 0);
        add(0, 0, 1, 0, 0, 1, 5, 0,      5, 0, 0, 1, 0);
        add(0, 1, 1, 1, 0, 7, 5, 3,      3, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 7, 5, 0,      2, 1, 0, 0, 0);
        add(0, 0, 1, 1, 0, 7, 0, 0,      0, 0, 0, 1, 1);
        add(0, 0, 1, 1, 0, 7, 0, 0,      0, 0, 0, 1, 1);
        // Full-range modulus, then reset alongside load.
        add(0, 1, 1, 1, 0, 15, 15, 4,    4, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 15, 15, 0,    3, 1, 0, 0, 0);
        add(1, 1, 1, 1, 0, 15, 15, 7,    0, 0, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].ld, vecs[i].en, vecs[i].up, vecs[i].sat,
                  vecs[i].step, vecs[i].lim, vecs[i].ldv);
            check_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].w, vecs[i].s,
                      vecs[i].mx, vecs[i].mn);
        end

        // Reset raised between edges must wait for the next rising edge.
        drive(0, 1, 0, 1, 0, 1, 9, 6);
        check_all("midrst_pre", 6, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        load  = 1'b0;
        #2;
        check("midrst_hold_q", int'(Q), 6);
        @(posedge clk);
        #1;
        check("midrst_post_q", int'(Q), 0);

        // Randomized traffic against the reference model.
        mq = 0;
        cur_lim = 9;
        for (int i = 0; i < 600; i++) begin
            logic r_rst, r_ld, r_en, r_up, r_sat;
            int   r_step, r_ldv;
            r_rst = ($urandom_range(0, 49) == 0);
            r_ld  = ($urandom_range(0, 9) == 0);
            r_en  = ($urandom_range(0, 4) != 0);
            r_up  = 1'($urandom_range(0, 1));
            r_sat = 1'($urandom_range(0, 1));
            r_step = $urandom_range(0, 15);
            r_ldv  = $urandom_range(0, 15);
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0:       cur_lim = 0;
                    1:       cur_lim = 15;
                    default: cur_lim = $urandom_range(0, 15);
                endcase
            end
            drive(r_rst, r_ld, r_en, r_up, r_sat, r_step, cur_lim, r_ldv);
            model(r_rst, r_ld, r_en, r_up, r_sat, r_step, cur_lim, r_ldv);
            check_all($sformatf("rnd%0d", i), mq, 1'(mw), 1'(ms),
                      (mq == cur_lim), (mq == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mod_step_up_down_counter.md
Name: mod_step_up_down_counter

Overview:
- Synchronous up/down counter with runtime-programmable modulus (0..limit), programmable step size, parallel load, and wrap or saturate selectable per cycle.
- Registered event pulses flag wrap-around and saturation.
- Next-generation general counter for timers, address generators and rate dividers throughout the sequential-circuit library.

Parameters:
N, 8, counter width in bits; also the width of limit, step and load_val.

Ports:
clk  input  1  rising-edge clock, the only clock
reset  input  1  synchronous, active-high reset
enable  input  1  count enable; when low, Q holds (load still honoured)
up  input  1  1 = count up, 0 = count down
sat_mode  input  1  0 = wrap at boundaries, 1 = saturate at boundaries
step  input  N  increment/decrement magnitude
limit  input  N  terminal value; legal range of Q is 0..limit
load  input  1  synchronous parallel load strobe
load_val  input  N  value to load
Q  output  N  current count (registered)
at_max  output  1  combinational, Q == limit
at_min  output  1  combinational, Q == 0
wrap_evt  output  1  registered one-cycle pulse: last update wrapped
sat_evt  output  1  registered one-cycle pulse: last update was clamped by saturation

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port name reset.
- Reset values: Q=0, wrap_evt=0, sat_evt=0. Reset asserted between edges has no effect until the next rising edge.
- Priority at each rising edge: reset > load > enable count > hold.
- Load: Q <= min(load_val, limit); wrap_evt=0, sat_evt=0.
- Effective step: step_eff = min(step, limit). This guarantees a single correction subtraction/addition suffices. Compute in N+1 bits with no lost carry.
- Out-of-range start: if enable and Q > limit (limit lowered at runtime), Q <= limit regardless of up or sat_mode, with no events.
- Up count (Q <= limit), sum = Q + step_eff:
  - sum <= limit: Q <= sum.
  - sum > limit, wrap: Q <= sum - (limit+1), wrap_evt=1.
  - sum > limit, saturate: Q <= limit, sat_evt=1.
- Down count (Q <= limit):
  - step_eff <= Q: Q <= Q - step_eff.
  - step_eff > Q, wrap: Q <= Q + (limit+1) - step_eff, wrap_evt=1.
  - step_eff > Q, saturate: Q <= 0, sat_evt=1.
- Exact landing on a boundary (sum == limit, or Q - step_eff == 0) is not an event.
- step=0 or limit=0: Q unchanged (0 when limit=0), no events.
- limit = 2^N-1: limit+1 = 2^N, held in N+1 bits; wrap behaves as natural modulo 2^N.
- Event timing: wrap_evt and sat_evt are high only in the cycle following the edge that produced the event, aligned with the new Q. They are 0 on any edge with no event, including hold and load.
- at_max and at_min are combinational from Q and limit, with no latency.
- Mode, direction and step are sampled at each edge. Changing them mid-count takes effect on the next edge, with no pipeline.

Decomposition:
- Shared package sequential_pkg:
  - localparams MODE_WRAP=1'b0 and MODE_SAT=1'b1.
  - localparams DIR_DOWN=1'b0 and DIR_UP=1'b1.
- One natural sub-module, mod_step_next: purely combinational next-state unit.
  - Inputs: Q, step, limit, up, sat_mode.
  - Outputs: q_next, wrap_flag, sat_flag.
- The top holds the Q, wrap_evt and sat_evt registers plus load/reset priority.

Test Plan:
1. N=4, reset=1 for 2 edges with enable=1 and load=1 -> Q=0, both events 0. Release; limit=9, up=1, step=1, sat_mode=0, 10 edges -> Q=1..9 then 0; wrap_evt=1 only with Q=0; at_max=1 while Q=9.
2. limit=9, step=3, up=1, sat_mode=1 from Q=0 -> Q=3,6,9 with no sat_evt; next edge Q=9 with sat_evt=1; next edge with enable=0 -> Q=9, sat_evt=0.
3. limit=9, step=3, up=0, sat_mode=0, Q=1 -> Q=8, wrap_evt=1. Repeat with sat_mode=1 from Q=1 -> Q=0, sat_evt=1. Then from Q=3 down by 3 -> Q=0, no event.
4. load=1, load_val=12, limit=9, enable=1 -> Q=9, no events (load beats count). Then load_val=4 -> Q=4.
5. Runtime limit change:
   - Q=9, limit lowered to 5, enable=1, up=0 -> Q=5, no events.
   - limit=5, step=7, up=1, wrap, Q=3 -> step_eff=5, Q=2, wrap_evt=1.
   - limit=0 -> Q stays 0, at_max=at_min=1.
6. N=4, limit=15, step=15, up=1, wrap, Q=4 -> Q=3, wrap_evt=1. Assert reset mid-count alongside load=1 -> Q=0 at next edge, wrap_evt=0.
